// File: rtl/obi_arb_pkg.sv
// Shared helpers for the OBI round-robin arbiter slice.
package obi_arb_pkg;

  // Index width for n masters; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/obi_rr_arbiter_if.sv
// Master-side and slave-side OBI signals of the arbiter, bundled for port use.
interface obi_rr_arbiter_if #(
    parameter int unsigned NR_MASTERS = 3,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NR_MASTERS-1:0]                   m_req_i;
    logic [NR_MASTERS-1:0][ADDR_WIDTH-1:0]   m_addr_i;
    logic [NR_MASTERS-1:0][DATA_WIDTH-1:0]   m_wdata_i;
    logic [NR_MASTERS-1:0]                   m_we_i;
    logic [NR_MASTERS-1:0][DATA_WIDTH/8-1:0] m_be_i;
    logic [NR_MASTERS-1:0]                   m_gnt_o;
    logic [NR_MASTERS-1:0]                   m_rvalid_o;
    logic [DATA_WIDTH-1:0]                   m_rdata_o;
    logic                                    s_req_o;
    logic                                    s_we_o;
    logic [ADDR_WIDTH-1:0]                   s_addr_o;
    logic [DATA_WIDTH/8-1:0]                 s_be_o;
    logic [DATA_WIDTH-1:0]                   s_wdata_o;
    logic                                    s_gnt_i;
    logic                                    s_rvalid_i;
    logic [DATA_WIDTH-1:0]                   s_rdata_i;

    // master: the arbiter itself, which acts as the single OBI master of the slave port
    modport master (
        input  m_req_i, m_addr_i, m_wdata_i, m_we_i, m_be_i, s_gnt_i, s_rvalid_i, s_rdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o
    );
    modport slave (
        output m_req_i, m_addr_i, m_wdata_i, m_we_i, m_be_i, s_gnt_i, s_rvalid_i, s_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o
    );
endinterface

// File: rtl/obi_id_fifo.sv
// Response-order FIFO: remembers which master owns each outstanding transaction.
module obi_id_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        // pointers wrap explicitly so non-power-of-two depths work
        if (push_ok) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        if (pop_ok)  rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end
endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin OBI arbiter: NR_MASTERS masters onto one slave, in-order responses.
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned NR_MASTERS      = 3,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    obi_rr_arbiter_if.master  bus,
    output logic [CNT_W-1:0]  outstanding_o,
    output logic              err_o
);
    localparam int unsigned IW = idx_width(NR_MASTERS);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic                    we;
        logic [DATA_WIDTH/8-1:0] be;
        logic [DATA_WIDTH-1:0]   wdata;
    } req_t;

    req_t [NR_MASTERS-1:0] m_reqs;
    req_t                  sel_req;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d;
    logic                  lock_q, lock_d, err_q, err_d;
    logic [IW-1:0]         sel_rr, sel, head;
    logic                  s_req, hs, pop, fifo_full, fifo_empty;

    for (genvar k = 0; k < NR_MASTERS; k++) begin : g_m
        assign m_reqs[k]         = '{addr: bus.m_addr_i[k], we: bus.m_we_i[k],
                                     be: bus.m_be_i[k], wdata: bus.m_wdata_i[k]};
        assign bus.m_gnt_o[k]    = hs  && (sel == IW'(k));
        assign bus.m_rvalid_o[k] = pop && (head == IW'(k));
    end

    always_comb begin
        int idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        sel_rr = rr_ptr_q;
        for (int i = 0; i < NR_MASTERS; i++) begin
            idx = (int'(rr_ptr_q) + i) % NR_MASTERS;
            if (!found && bus.m_req_i[idx]) begin
                found  = 1'b1;
                sel_rr = IW'(idx);
            end
        end
    end

    // A pending (ungranted) offer keeps its master until the handshake completes
    assign sel     = lock_q ? lock_idx_q : sel_rr;
    assign sel_req = m_reqs[sel];
    assign s_req   = ~rst_i & (|bus.m_req_i) & ~fifo_full;
    assign hs      = s_req & bus.s_gnt_i;
    assign pop     = ~rst_i & bus.s_rvalid_i & ~fifo_empty;

    assign bus.s_req_o   = s_req;
    assign bus.s_addr_o  = sel_req.addr;
    assign bus.s_we_o    = sel_req.we;
    assign bus.s_be_o    = sel_req.be;
    assign bus.s_wdata_o = sel_req.wdata;
    assign bus.m_rdata_o = bus.s_rdata_i;
    assign err_o         = err_q;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q | (bus.s_rvalid_i & fifo_empty);
        if (hs) begin
            rr_ptr_d = (sel == IW'(NR_MASTERS - 1)) ? '0 : sel + 1'b1;
            lock_d   = 1'b0;
        end else if (s_req) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

    obi_id_fifo #(.WIDTH(IW), .DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (hs),
        .data_i (sel),
        .pop_i  (pop),
        .head_o (head),
        .count_o(outstanding_o),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed bench for obi_rr_arbiter: 3 masters, MAX_OUTSTANDING=2.
module tb_obi_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] outst;
    logic       err;
    int         ncmp = 0;
    int         nfail = 0;

    localparam logic [31:0] A0 = 32'h0000_0040;
    localparam logic [31:0] A1 = 32'h0000_0100;
    localparam logic [31:0] A2 = 32'h0000_0200;

    always #5 clk = ~clk;

    obi_rr_arbiter_if #(.NR_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    obi_rr_arbiter #(.NR_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus.master),
        .outstanding_o(outst),
        .err_o        (err)
    );

    typedef struct {
        logic [2:0]  req;
        logic        sgnt;
        logic        srv;
        logic        exp_sreq;
        logic [2:0]  exp_gnt;
        logic [2:0]  exp_rv;
        logic [31:0] exp_addr;
        logic [1:0]  exp_out;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, check combinational outputs mid-cycle, then advance past the edge.
    task automatic apply(input string tag, input logic [2:0] req, input logic sgnt, input logic srv,
                         input logic exp_sreq, input logic [2:0] exp_gnt, input logic [2:0] exp_rv,
                         input logic [31:0] exp_addr, input logic [1:0] exp_out);
        logic [31:0] rd;
        rd = $urandom;
        bus.m_req_i    = req;
        bus.s_gnt_i    = sgnt;
        bus.s_rvalid_i = srv;
        bus.s_rdata_i  = rd;
        @(negedge clk);
        chk({tag, " s_req"}, 32'(bus.s_req_o), 32'(exp_sreq));
        chk({tag, " m_gnt"}, 32'(bus.m_gnt_o), 32'(exp_gnt));
        chk({tag, " m_rvalid"}, 32'(bus.m_rvalid_o), 32'(exp_rv));
        chk({tag, " outstanding"}, 32'(outst), 32'(exp_out));
        if (exp_sreq) chk({tag, " s_addr"}, bus.s_addr_o, exp_addr);
        if (exp_rv != 3'b000) chk({tag, " m_rdata"}, bus.m_rdata_o, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.m_req_i    = '0;
        bus.s_gnt_i    = 1'b0;
        bus.s_rvalid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.m_addr_i[0] = A0;  bus.m_addr_i[1] = A1;  bus.m_addr_i[2] = A2;
        bus.m_wdata_i   = '0;
        bus.m_we_i      = '0;
        bus.m_be_i      = '1;
        bus.s_rdata_i   = '0;

        // Outputs forced low while reset is held, even with live inputs
        bus.m_req_i = 3'b111; bus.s_gnt_i = 1'b1; bus.s_rvalid_i = 1'b1;
        #2;
        chk("rst s_req", 32'(bus.s_req_o), 32'd0);
        chk("rst m_gnt", 32'(bus.m_gnt_o), 32'd0);
        chk("rst m_rvalid", 32'(bus.m_rvalid_o), 32'd0);
        chk("rst outstanding", 32'(outst), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        do_reset();

        // Continuous requests (0,1,2,0,1,2), then a single zero-wait read by master 1
        tbl[0] = '{3'b111, 1, 0, 1, 3'b001, 3'b000, A0, 2'd0};
        tbl[1] = '{3'b111, 1, 1, 1, 3'b010, 3'b001, A1, 2'd1};
        tbl[2] = '{3'b111, 1, 1, 1, 3'b100, 3'b010, A2, 2'd1};
        tbl[3] = '{3'b111, 1, 1, 1, 3'b001, 3'b100, A0, 2'd1};
        tbl[4] = '{3'b111, 1, 1, 1, 3'b010, 3'b001, A1, 2'd1};
        tbl[5] = '{3'b111, 1, 1, 1, 3'b100, 3'b010, A2, 2'd1};
        tbl[6] = '{3'b000, 0, 1, 0, 3'b000, 3'b100, A0, 2'd1};
        tbl[7] = '{3'b010, 1, 0, 1, 3'b010, 3'b000, A1, 2'd0};
        tbl[8] = '{3'b000, 0, 1, 0, 3'b000, 3'b010, A0, 2'd1};
        for (int i = 0; i < 9; i++)
            apply($sformatf("vec%0d", i), tbl[i].req, tbl[i].sgnt, tbl[i].srv, tbl[i].exp_sreq,
                  tbl[i].exp_gnt, tbl[i].exp_rv, tbl[i].exp_addr, tbl[i].exp_out);
        chk("vec err", 32'(err), 32'd0);

        // Withheld grant: master 2 stays selected although rr_ptr=0 favours master 0
        do_reset();
        apply("lock0", 3'b100, 0, 0, 1, 3'b000, 3'b000, A2, 2'd0);
        apply("lock1", 3'b101, 0, 0, 1, 3'b000, 3'b000, A2, 2'd0);
        apply("lock2", 3'b101, 0, 0, 1, 3'b000, 3'b000, A2, 2'd0);
        apply("lock3", 3'b101, 1, 0, 1, 3'b100, 3'b000, A2, 2'd0);
        apply("lock4", 3'b001, 1, 0, 1, 3'b001, 3'b000, A0, 2'd1);
        apply("lock5", 3'b000, 0, 1, 0, 3'b000, 3'b100, A0, 2'd2);
        apply("lock6", 3'b000, 0, 1, 0, 3'b000, 3'b001, A0, 2'd1);

        // Full at 2: third request blocked, including in a cycle that also pops
        apply("full0", 3'b111, 1, 0, 1, 3'b010, 3'b000, A1, 2'd0);
        apply("full1", 3'b111, 1, 0, 1, 3'b100, 3'b000, A2, 2'd1);
        apply("full2", 3'b111, 1, 0, 0, 3'b000, 3'b000, A0, 2'd2);
        apply("full3", 3'b111, 1, 1, 0, 3'b000, 3'b010, A0, 2'd2);
        apply("full4", 3'b111, 1, 1, 1, 3'b001, 3'b100, A0, 2'd1);
        apply("full5", 3'b000, 0, 1, 0, 3'b000, 3'b001, A0, 2'd1);

        // Spurious rvalid with nothing outstanding
        chk("err before", 32'(err), 32'd0);
        apply("spur0", 3'b000, 0, 1, 0, 3'b000, 3'b000, A0, 2'd0);
        chk("err set", 32'(err), 32'd1);
        apply("spur1", 3'b000, 0, 0, 0, 3'b000, 3'b000, A0, 2'd0);
        apply("spur2", 3'b000, 0, 0, 0, 3'b000, 3'b000, A0, 2'd0);
        chk("err sticky", 32'(err), 32'd1);

        // Reset with two outstanding, then a stale rvalid
        apply("rst0", 3'b011, 1, 0, 1, 3'b010, 3'b000, A1, 2'd0);
        apply("rst1", 3'b011, 1, 0, 1, 3'b001, 3'b000, A0, 2'd1);
        chk("pre-rst outstanding", 32'(outst), 32'd2);
        bus.m_req_i = 3'b011; bus.s_gnt_i = 1'b1; bus.s_rvalid_i = 1'b1;
        rst = 1'b1;
        #1;
        chk("async outstanding", 32'(outst), 32'd0);
        chk("async err", 32'(err), 32'd0);
        chk("async s_req", 32'(bus.s_req_o), 32'd0);
        chk("async m_gnt", 32'(bus.m_gnt_o), 32'd0);
        chk("async m_rvalid", 32'(bus.m_rvalid_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply("stale", 3'b000, 0, 1, 0, 3'b000, 3'b000, A0, 2'd0);
        chk("stale err", 32'(err), 32'd1);
        chk("stale outstanding", 32'(outst), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
